// File: rtl/cf_fft_pkg.sv
// Shared types and helpers for the FFT phase selector: FSM state encoding and
// the channel-to-phase-code mapping used by the code mux.
package cf_fft_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    AUTO = 1'b1
  } state_t;

  // Channel k answers to (base + k*step) mod 2^sel_w; masking wraps the code.
  function automatic int phase_code(input int base, input int step,
                                    input int k, input int sel_w);
    return (base + k * step) & ((1 << sel_w) - 1);
  endfunction

endpackage

// File: rtl/cf_fft_phase_sel_if.sv
// Data/control bundle between the stage address generator, the phase
// selector and the butterfly operand registers.
interface cf_fft_phase_sel_if #(
  parameter int DW    = 1,
  parameter int N_CH  = 3,
  parameter int SEL_W = 3
);
  logic                 enable_i;
  logic                 start_i;
  logic                 mode_i;
  logic [SEL_W-1:0]     sel_i;
  logic [N_CH*DW-1:0]   data_i;
  logic [DW-1:0]        data_o;
  logic [SEL_W-1:0]     sel_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 done_o;

  // valid_o marks a fresh data_o/sel_o pair; there is no ready, the consumer
  // must take every valid sample. Outputs (pulses included) freeze while enable_i=0.
  modport master (
    output enable_i, start_i, mode_i, sel_i, data_i,
    input  data_o, sel_o, valid_o, busy_o, done_o
  );

  modport slave (
    input  enable_i, start_i, mode_i, sel_i, data_i,
    output data_o, sel_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/cf_fft_code_mux.sv
// Combinational phase-code to channel select; lowest channel index wins on
// aliased codes and unmapped codes return DEFAULT_VAL.
module cf_fft_code_mux
  import cf_fft_pkg::*;
#(
  parameter int             DW          = 1,
  parameter int             N_CH        = 3,
  parameter int             SEL_W       = 3,
  parameter int             CODE_BASE   = 2,
  parameter int             CODE_STEP   = 2,
  parameter logic [DW-1:0]  DEFAULT_VAL = '1
) (
  input  logic [SEL_W-1:0]   i_code,
  input  logic [N_CH*DW-1:0] i_data,
  output logic [DW-1:0]      o_data
);

  // Scanning from the top channel down lets the lowest index overwrite last.
  always_comb begin
    o_data = DEFAULT_VAL;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (int'(i_code) == phase_code(CODE_BASE, CODE_STEP, k, SEL_W)) begin
        o_data = i_data[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/cf_fft_phase_sel.sv
// Registered phase-code selector with external-select and auto-sweep modes;
// FSM, phase counter and output registers live here.
module cf_fft_phase_sel
  import cf_fft_pkg::*;
#(
  parameter int             DW          = 1,
  parameter int             N_CH        = 3,
  parameter int             SEL_W       = 3,
  parameter int             CODE_BASE   = 2,
  parameter int             CODE_STEP   = 2,
  parameter logic [DW-1:0]  DEFAULT_VAL = '1
) (
  input  logic                clock_c,
  input  logic                reset_i,
  cf_fft_phase_sel_if.slave   bus,
  output state_t              o_dbg_state
);

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_next_cnt;
  logic [SEL_W-1:0] w_code;
  logic [DW-1:0]    w_mux_data;
  logic             w_load;
  logic             w_valid;
  logic             w_busy;
  logic             w_done;

  logic [DW-1:0]    r_data;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  cf_fft_code_mux #(
    .DW          (DW),
    .N_CH        (N_CH),
    .SEL_W       (SEL_W),
    .CODE_BASE   (CODE_BASE),
    .CODE_STEP   (CODE_STEP),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_mux (
    .i_code (w_code),
    .i_data (bus.data_i),
    .o_data (w_mux_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_code       = r_cnt;
    w_load       = 1'b0;
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!bus.mode_i) begin
          w_code  = bus.sel_i;
          w_load  = 1'b1;
          w_valid = 1'b1;
        end else if (bus.start_i) begin
          w_next_state = AUTO;
          w_next_cnt   = '0;
        end
      end
      AUTO: begin
        w_load     = 1'b1;
        w_valid    = 1'b1;
        w_busy     = 1'b1;
        // Natural SEL_W-bit overflow brings the counter back to 0 after the last code.
        w_next_cnt = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_c or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= DEFAULT_VAL;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.enable_i) begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_load) begin
        r_data <= w_mux_data;
        r_sel  <= w_code;
      end
    end
  end

  // busy_o is registered with the sample so it spans exactly the swept samples.
  assign bus.data_o  = r_data;
  assign bus.sel_o   = r_sel;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign o_dbg_state = r_state;

endmodule
